seg7_capture: RTL

- Receiving end of the multiplexed 7-segment display bus.
- Watches the active-low segment lines and the one-hot digit strobes driven by the display scanner.
- Waits for each digit's pattern to settle, then maps the pattern back to a digit code and stores it per position.
- Flags unknown patterns and signals when a full display frame has been captured.
- Used for display self-check and loopback verification of the BCD-to-segment path.

---
 rtl/seg7_capture.sv | 106 ++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - multiplexed 7-segment bus receiver that decodes and stores each digit
module seg7_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg_in,
    input  logic [NDIG-1:0]     dig_en,
    output logic [4*NDIG-1:0]   code_out,
    output logic [NDIG-1:0]     seen_out,
    output logic                frame_valid,
    output logic                pat_err,
    output logic                sel_err
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYC);

    logic [6:0]      seg_r;
    logic [6:0]      seg_p;
    logic [NDIG-1:0] dig_r;
    logic [NDIG-1:0] dig_p;
    logic [7:0]      run_cnt;

    logic            same;
    logic            capture;
    logic            one_hot;
    logic            multi_hot;
    logic [3:0]      dec_code;
    logic            dec_bad;
    logic [NDIG-1:0] seen_next;

    always_comb begin
        same      = ({dig_r, seg_r} == {dig_p, seg_p});
        // Fires only on the edge where the run counter reaches its limit;
        // with a limit of 1 every change of the sample is itself a capture.
        capture   = same ? (run_cnt == RUN_MAX - 8'd1) : (RUN_MAX == 8'd1);
        one_hot   = (dig_r != '0) && ((dig_r & (dig_r - NDIG'(1))) == '0);
        multi_hot = (dig_r != '0) && !one_hot;
        seen_next = seen_out | dig_r;
    end

    always_comb begin
        dec_code = 4'hF;
        dec_bad  = 1'b0;
        case (seg_r)
            7'h40:   dec_code = 4'h0;
            7'h79:   dec_code = 4'h1;
            7'h24:   dec_code = 4'h2;
            7'h30:   dec_code = 4'h3;
            7'h19:   dec_code = 4'h4;
            7'h12:   dec_code = 4'h5;
            7'h03:   dec_code = 4'h6;
            7'h78:   dec_code = 4'h7;
            7'h00:   dec_code = 4'h8;
            7'h18:   dec_code = 4'h9;
            7'h7F:   dec_code = 4'hA;
            default: dec_bad  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r       <= '0;
            seg_p       <= '0;
            dig_r       <= '0;
            dig_p       <= '0;
            run_cnt     <= '0;
            code_out    <= {NDIG{4'hA}};
            seen_out    <= '0;
            frame_valid <= 1'b0;
            pat_err     <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            seg_r       <= seg_in[6:0];
            dig_r       <= dig_en;
            seg_p       <= seg_r;
            dig_p       <= dig_r;
            frame_valid <= 1'b0;
            pat_err     <= 1'b0;
            sel_err     <= 1'b0;

            if (!same)
                run_cnt <= 8'd1;
            else if (run_cnt < RUN_MAX)
                run_cnt <= run_cnt + 8'd1;

            if (capture && one_hot) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (dig_r[i])
                        code_out[4*i +: 4] <= dec_code;
                end
                pat_err <= dec_bad;
                if (&seen_next) begin
                    frame_valid <= 1'b1;
                    seen_out    <= '0;
                end else begin
                    seen_out    <= seen_next;
                end
            end else if (capture && multi_hot) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule
